// File: rtl/regfile_wb_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// regfile_ctrl_pkg: shared widths and enums for the RF write-port scoreboard.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;
  localparam int XLEN       = 32;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_BUF  = 2'd2,
    SRC_LU   = 2'd3
  } wr_src_e;

  typedef enum logic [0:0] {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;
endpackage

`default_nettype wire

// File: rtl/regfile_wb_scoreboard_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_scoreboard_if: Decode/WB/long-unit/RF bundle around the scoreboard.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface regfile_wb_scoreboard_if #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 4
);
  import regfile_ctrl_pkg::*;

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic                  issue_valid;
  logic                  issue_long;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic [REG_ADDR_W-1:0] issue_rs1;
  logic [REG_ADDR_W-1:0] issue_rs2;
  logic                  issue_use_rs1;
  logic                  issue_use_rs2;
  logic                  flush_d;
  logic                  stall_d;
  logic                  issue_accept;
  logic                  wb_valid;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  lu_valid;
  logic [REG_ADDR_W-1:0] lu_rd;
  logic [XLEN-1:0]       lu_data;
  logic                  lu_ready;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_rd;
  logic [XLEN-1:0]       rf_wd;
  logic [CNT_W-1:0]      busy_count;

  modport slave (
    input  issue_valid, issue_long, issue_rd, issue_rs1, issue_rs2,
    input  issue_use_rs1, issue_use_rs2, flush_d,
    input  wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
    output stall_d, issue_accept, lu_ready, rf_we, rf_rd, rf_wd, busy_count
  );

  modport master (
    output issue_valid, issue_long, issue_rd, issue_rs1, issue_rs2,
    output issue_use_rs1, issue_use_rs2, flush_d,
    output wb_valid, wb_rd, wb_data, lu_valid, lu_rd, lu_data,
    input  stall_d, issue_accept, lu_ready, rf_we, rf_rd, rf_wd, busy_count
  );
endinterface

`default_nettype wire

// File: rtl/regfile_wb_scoreboard_pending_table.sv
// ---------------------------------------------------------------------------
// regfile_pending_table: per-register pending bits and in-flight long-op count.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_pending_table #(
  parameter int NREGS           = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   issue_en,
  input  logic [regfile_ctrl_pkg::REG_ADDR_W-1:0] issue_rd,
  input  logic                                   retire_en,
  input  logic [regfile_ctrl_pkg::REG_ADDR_W-1:0] retire_rd,
  input  logic [regfile_ctrl_pkg::REG_ADDR_W-1:0] rs1,
  input  logic [regfile_ctrl_pkg::REG_ADDR_W-1:0] rs2,
  output logic                                   pend_rs1,
  output logic                                   pend_rs2,
  output logic [NREGS-1:0]                       pending,
  output logic [CNT_W-1:0]                       busy_count
);
  import regfile_ctrl_pkg::*;

  logic [NREGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] busy_count_q, busy_count_d;
  logic [NREGS-1:0] set_mask, clr_mask;

  // x0 is masked out of the set path so it can never become pending.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    set_mask[issue_rd]  = issue_en & (issue_rd != '0);
    clr_mask[retire_rd] = retire_en;
    pending_d = (pending_q & ~clr_mask) | set_mask;

    busy_count_d = busy_count_q;
    case ({issue_en, retire_en})
      2'b10:   busy_count_d = busy_count_q + CNT_W'(1);
      2'b01:   busy_count_d = busy_count_q - CNT_W'(1);
      default: busy_count_d = busy_count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= '0;
      busy_count_q <= '0;
    end else begin
      pending_q    <= pending_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign pend_rs1   = pending_q[rs1];
  assign pend_rs2   = pending_q[rs2];
  assign pending    = pending_q;
  assign busy_count = busy_count_q;

  a_busy_bounded: assert property (@(posedge clk) disable iff (rst)
    (busy_count_q <= CNT_W'(MAX_OUTSTANDING)) &&
    !(retire_en && !issue_en && busy_count_q == '0));
endmodule

`default_nettype wire

// File: rtl/regfile_wb_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_wb_scoreboard: RF write-port arbiter (WB > buffer > long unit) + Decode stall.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_wb_scoreboard #(
  parameter int XLEN            = 32,
  parameter int NREGS           = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  regfile_wb_scoreboard_if.slave bus
);
  import regfile_ctrl_pkg::*;

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  buf_state_e            buf_state_q, buf_state_d;
  logic [REG_ADDR_W-1:0] buf_rd_q, buf_rd_d;
  logic [XLEN-1:0]       buf_data_q, buf_data_d;

  wr_src_e               wr_src;
  logic [NREGS-1:0]      pending;
  logic                  pend_rs1, pend_rs2;
  logic [CNT_W-1:0]      busy_count;
  logic                  stall, accept, lu_ready, retire_en;
  logic [REG_ADDR_W-1:0] retire_rd;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_rd;
  logic [XLEN-1:0]       rf_wd;

  regfile_pending_table #(
    .NREGS          (NREGS),
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .CNT_W          (CNT_W)
  ) u_pending (
    .clk       (clk),
    .rst       (rst),
    .issue_en  (accept & bus.issue_long),
    .issue_rd  (bus.issue_rd),
    .retire_en (retire_en),
    .retire_rd (retire_rd),
    .rs1       (bus.issue_rs1),
    .rs2       (bus.issue_rs2),
    .pend_rs1  (pend_rs1),
    .pend_rs2  (pend_rs2),
    .pending   (pending),
    .busy_count(busy_count)
  );

  // Stall only looks at registered pending bits: a retire unstalls one cycle later.
  always_comb begin
    stall = 1'b0;
    if (!rst) begin
      stall = (bus.issue_use_rs1 & pend_rs1) |
              (bus.issue_use_rs2 & pend_rs2) |
              pending[bus.issue_rd] |
              (bus.issue_long & (busy_count == CNT_W'(MAX_OUTSTANDING)));
    end
  end

  assign accept   = ~rst & bus.issue_valid & ~stall & ~bus.flush_d;
  assign lu_ready = ~rst & (buf_state_q == BUF_EMPTY);

  always_comb begin
    wr_src    = SRC_NONE;
    rf_we     = 1'b0;
    rf_rd     = '0;
    rf_wd     = '0;
    retire_en = 1'b0;
    retire_rd = bus.lu_rd;
    if (!rst) begin
      if (bus.wb_valid)                wr_src = SRC_WB;
      else if (buf_state_q == BUF_FULL) wr_src = SRC_BUF;
      else if (bus.lu_valid)           wr_src = SRC_LU;
    end
    case (wr_src)
      SRC_WB: begin
        rf_we = 1'b1;
        rf_rd = bus.wb_rd;
        rf_wd = bus.wb_data;
      end
      SRC_BUF: begin
        rf_we     = 1'b1;
        rf_rd     = buf_rd_q;
        rf_wd     = buf_data_q;
        retire_en = 1'b1;
        retire_rd = buf_rd_q;
      end
      SRC_LU: begin
        rf_we     = 1'b1;
        rf_rd     = bus.lu_rd;
        rf_wd     = bus.lu_data;
        retire_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Buffer fills only when WB owns the port, and drains only when WB is idle.
  always_comb begin
    buf_state_d = buf_state_q;
    buf_rd_d    = buf_rd_q;
    buf_data_d  = buf_data_q;
    if (bus.lu_valid & lu_ready & bus.wb_valid) begin
      buf_state_d = BUF_FULL;
      buf_rd_d    = bus.lu_rd;
      buf_data_d  = bus.lu_data;
    end else if (wr_src == SRC_BUF) begin
      buf_state_d = BUF_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_state_q <= BUF_EMPTY;
      buf_rd_q    <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_state_q <= buf_state_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
    end
  end

  assign bus.stall_d      = stall;
  assign bus.issue_accept = accept;
  assign bus.lu_ready     = lu_ready;
  assign bus.rf_we        = rf_we;
  assign bus.rf_rd        = rf_rd;
  assign bus.rf_wd        = rf_wd;
  assign bus.busy_count   = busy_count;

  a_wb_not_pending: assert property (@(posedge clk) disable iff (rst)
    (bus.wb_valid && bus.wb_rd != '0) |-> !pending[bus.wb_rd]);

  a_lu_rd_pending: assert property (@(posedge clk) disable iff (rst)
    (bus.lu_valid && lu_ready && bus.lu_rd != '0) |-> pending[bus.lu_rd]);
endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_regfile_wb_scoreboard: directed vector table plus random run against a queue model.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_wb_scoreboard;
  localparam int MAXO     = 4;
  localparam int N_RANDOM = 3000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_wb_scoreboard_if #(.XLEN(32), .MAX_OUTSTANDING(MAXO)) bus ();

  regfile_wb_scoreboard #(
    .XLEN           (32),
    .NREGS          (32),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        r, iv, il;
    logic [4:0]  rd, rs1, rs2;
    logic        u1, u2, fl, wv;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        st, acc, lr, we;
    logic [4:0]  erd;
    logic [31:0] ewd;
    logic [2:0]  bc;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic r, input logic iv, input logic il, input logic [4:0] rd,
    input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
    input logic fl, input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
    input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
    input logic st, input logic acc, input logic lr, input logic we,
    input logic [4:0] erd, input logic [31:0] ewd, input logic [2:0] bc);
    vec_t v;
    v.r = r;   v.iv = iv;  v.il = il;  v.rd = rd;
    v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
    v.fl = fl; v.wv = wv;  v.wrd = wrd; v.wd = wd;
    v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.st = st; v.acc = acc; v.lr = lr; v.we = we;
    v.erd = erd; v.ewd = ewd; v.bc = bc;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    rst               = v.r;
    bus.issue_valid   = v.iv;
    bus.issue_long    = v.il;
    bus.issue_rd      = v.rd;
    bus.issue_rs1     = v.rs1;
    bus.issue_rs2     = v.rs2;
    bus.issue_use_rs1 = v.u1;
    bus.issue_use_rs2 = v.u2;
    bus.flush_d       = v.fl;
    bus.wb_valid      = v.wv;
    bus.wb_rd         = v.wrd;
    bus.wb_data       = v.wd;
    bus.lu_valid      = v.lv;
    bus.lu_rd         = v.lrd;
    bus.lu_data       = v.ld;
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    chk({tag, " stall_d"},      {31'd0, bus.stall_d},      {31'd0, v.st});
    chk({tag, " issue_accept"}, {31'd0, bus.issue_accept}, {31'd0, v.acc});
    chk({tag, " lu_ready"},     {31'd0, bus.lu_ready},     {31'd0, v.lr});
    chk({tag, " rf_we"},        {31'd0, bus.rf_we},        {31'd0, v.we});
    chk({tag, " rf_rd"},        {27'd0, bus.rf_rd},        {27'd0, v.erd});
    chk({tag, " rf_wd"},        bus.rf_wd,                 v.ewd);
    chk({tag, " busy_count"},   {29'd0, bus.busy_count},   {29'd0, v.bc});
  endtask

  // Reference state: pending set, in-flight long destinations, holding buffer.
  bit          pend[32];
  int          busy;
  int          out_q[$];
  bit          buf_full;
  logic [4:0]  buf_rd_m;
  logic [31:0] buf_data_m;

  vec_t vt[$];

  initial begin
    vec_t v;
    int   lidx;

    //        r iv il rd  rs1 u1 rs2 u2 fl wv wrd wd          lv lrd ld            st acc lr we erd ewd           bc
    vt.push_back(mk(1,1,1, 5, 0,0, 0,0, 0, 1, 3, 32'h1,      0, 0, 0,            0,0,0,0, 0, 0,            0)); // rst blocks writes
    vt.push_back(mk(0,0,0, 0, 0,0, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,0,1,0, 0, 0,            0)); // idle
    vt.push_back(mk(0,1,1, 5, 0,0, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,1,1,0, 0, 0,            0)); // long rd5
    vt.push_back(mk(0,1,0, 8, 5,1, 0,0, 0, 0, 0, 0,          0, 0, 0,            1,0,1,0, 0, 0,            1)); // RAW on x5
    vt.push_back(mk(0,1,0, 8, 5,1, 0,0, 0, 0, 0, 0,          1, 5, 32'hDEADBEEF, 1,0,1,1, 5, 32'hDEADBEEF, 1));
    vt.push_back(mk(0,1,0, 8, 5,1, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,1,1,0, 0, 0,            0)); // released
    vt.push_back(mk(0,1,1, 7, 0,0, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,1,1,0, 0, 0,            0)); // long rd7
    vt.push_back(mk(0,0,0, 0, 0,0, 0,0, 0, 1, 3, 32'h5555,   1, 7, 32'h3333,     0,0,1,1, 3, 32'h5555,     1)); // conflict
    vt.push_back(mk(0,0,0, 0, 0,0, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,0,0,1, 7, 32'h3333,     1)); // drain
    vt.push_back(mk(0,1,0, 0, 7,1, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,1,1,0, 0, 0,            0));
    vt.push_back(mk(0,1,1, 7, 0,0, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,1,1,0, 0, 0,            0));
    vt.push_back(mk(0,0,0, 0, 0,0, 0,0, 0, 1, 3, 32'h1111,   1, 7, 32'h2222,     0,0,1,1, 3, 32'h1111,     1));
    vt.push_back(mk(0,0,0, 0, 0,0, 0,0, 0, 1, 4, 32'h4444,   0, 0, 0,            0,0,0,1, 4, 32'h4444,     1)); // FULL holds
    vt.push_back(mk(0,0,0, 0, 0,0, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,0,0,1, 7, 32'h2222,     1));
    vt.push_back(mk(0,1,1, 1, 0,0, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,1,1,0, 0, 0,            0)); // fill to limit
    vt.push_back(mk(0,1,1, 2, 0,0, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,1,1,0, 0, 0,            1));
    vt.push_back(mk(0,1,1, 3, 0,0, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,1,1,0, 0, 0,            2));
    vt.push_back(mk(0,1,1, 4, 0,0, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,1,1,0, 0, 0,            3));
    vt.push_back(mk(0,1,1,20, 0,0, 0,0, 0, 0, 0, 0,          0, 0, 0,            1,0,1,0, 0, 0,            4)); // limit stall
    vt.push_back(mk(0,1,1,20, 0,0, 0,0, 0, 0, 0, 0,          1, 2, 32'hAAAA,     1,0,1,1, 2, 32'hAAAA,     4));
    vt.push_back(mk(0,1,1,20, 0,0, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,1,1,0, 0, 0,            3));
    vt.push_back(mk(0,0,0, 0, 0,0, 0,0, 0, 0, 0, 0,          1, 1, 32'h1,        0,0,1,1, 1, 32'h1,        4));
    vt.push_back(mk(0,0,0, 0, 0,0, 0,0, 0, 0, 0, 0,          1, 3, 32'h3,        0,0,1,1, 3, 32'h3,        3));
    vt.push_back(mk(0,0,0, 0, 0,0, 0,0, 0, 0, 0, 0,          1, 4, 32'h4,        0,0,1,1, 4, 32'h4,        2));
    vt.push_back(mk(0,0,0, 0, 0,0, 0,0, 0, 0, 0, 0,          1,20, 32'h20,       0,0,1,1,20, 32'h20,       1));
    vt.push_back(mk(0,1,1, 0, 0,0, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,1,1,0, 0, 0,            0)); // long rd0
    vt.push_back(mk(0,1,0, 0, 0,1, 0,1, 0, 0, 0, 0,          0, 0, 0,            0,1,1,0, 0, 0,            1)); // x0 sources
    vt.push_back(mk(0,1,1, 9, 0,0, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,1,1,0, 0, 0,            1));
    vt.push_back(mk(0,1,0, 9, 0,0, 0,0, 0, 0, 0, 0,          0, 0, 0,            1,0,1,0, 0, 0,            2)); // WAW
    vt.push_back(mk(0,1,1,10, 0,0, 0,0, 1, 0, 0, 0,          0, 0, 0,            0,0,1,0, 0, 0,            2)); // flushed
    vt.push_back(mk(0,1,0,11,10,1, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,1,1,0, 0, 0,            2));
    vt.push_back(mk(0,0,0, 0, 0,0, 0,0, 0, 0, 0, 0,          1, 0, 32'h12345678, 0,0,1,1, 0, 32'h12345678, 2));
    vt.push_back(mk(0,1,0,12, 0,0, 9,1, 0, 0, 0, 0,          0, 0, 0,            1,0,1,0, 0, 0,            1)); // rs2 RAW
    vt.push_back(mk(0,1,1, 6, 0,0, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,1,1,0, 0, 0,            1));
    vt.push_back(mk(0,0,0, 0, 0,0, 0,0, 0, 1, 3, 32'h7,      1, 9, 32'h9,        0,0,1,1, 3, 32'h7,        2));
    vt.push_back(mk(1,1,0, 6, 6,1, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,0,0,0, 0, 0,            2)); // rst mid-op
    vt.push_back(mk(0,1,0, 9, 6,1, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,1,1,0, 0, 0,            0));
    vt.push_back(mk(0,1,0, 6, 9,1, 0,0, 0, 0, 0, 0,          0, 0, 0,            0,1,1,0, 0, 0,            0));

    v = mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    apply(v);
    repeat (3) @(posedge clk);

    foreach (vt[i]) begin
      @(negedge clk);
      apply(vt[i]);
      #2;
      check_vec(vt[i], $sformatf("row%0d", i));
    end

    // Random phase, starting from reset so the model and DUT agree.
    foreach (pend[i]) pend[i] = 1'b0;
    busy     = 0;
    buf_full = 1'b0;
    out_q.delete();
    @(negedge clk);
    apply(mk(1,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));

    for (int cyc = 0; cyc < N_RANDOM; cyc++) begin
      @(negedge clk);
      v.r   = ($urandom_range(0, 99) < 2);
      v.iv  = $urandom_range(0, 1) == 1;
      v.il  = ($urandom_range(0, 9) < 4);
      v.rd  = ($urandom_range(0, 99) < 80) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      v.rs1 = 5'($urandom_range(0, 7));
      v.rs2 = 5'($urandom_range(0, 7));
      v.u1  = $urandom_range(0, 1) == 1;
      v.u2  = $urandom_range(0, 1) == 1;
      v.fl  = ($urandom_range(0, 9) == 0);
      v.wv  = ($urandom_range(0, 9) < 4);
      v.wrd = 5'($urandom_range(0, 31));
      if (pend[v.wrd]) v.wrd = 5'd0;
      v.wd  = $urandom;
      v.lv  = 1'b0;
      v.lrd = 5'd0;
      v.ld  = $urandom;
      lidx  = 0;
      if (out_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        lidx  = $urandom_range(0, out_q.size() - 1);
        v.lv  = 1'b1;
        v.lrd = 5'(out_q[lidx]);
      end

      v.bc  = 3'(busy);
      v.st  = 1'b0;
      v.acc = 1'b0;
      v.lr  = 1'b0;
      v.we  = 1'b0;
      v.erd = 5'd0;
      v.ewd = 32'd0;
      if (!v.r) begin
        v.st  = (v.u1 && pend[v.rs1]) || (v.u2 && pend[v.rs2]) || pend[v.rd] ||
                (v.il && busy == MAXO);
        v.acc = v.iv && !v.st && !v.fl;
        v.lr  = !buf_full;
        if (v.wv) begin
          v.we = 1'b1; v.erd = v.wrd; v.ewd = v.wd;
        end else if (buf_full) begin
          v.we = 1'b1; v.erd = buf_rd_m; v.ewd = buf_data_m;
        end else if (v.lv) begin
          v.we = 1'b1; v.erd = v.lrd; v.ewd = v.ld;
        end
      end

      apply(v);
      #2;
      check_vec(v, $sformatf("rnd%0d", cyc));

      if (v.r) begin
        foreach (pend[i]) pend[i] = 1'b0;
        busy     = 0;
        buf_full = 1'b0;
        out_q.delete();
      end else begin
        if (v.acc && v.il) begin
          busy++;
          if (v.rd != 5'd0) pend[v.rd] = 1'b1;
          out_q.push_back(int'(v.rd));
        end
        if (v.wv && v.lv && !buf_full) begin
          buf_full   = 1'b1;
          buf_rd_m   = v.lrd;
          buf_data_m = v.ld;
          out_q.delete(lidx);
        end else if (!v.wv && buf_full) begin
          pend[buf_rd_m] = 1'b0;
          busy--;
          buf_full = 1'b0;
        end else if (!v.wv && v.lv) begin
          pend[v.lrd] = 1'b0;
          busy--;
          out_q.delete(lidx);
        end
      end
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
